// File: rtl/sram_pixel_writer.sv
// Write-side SRAM pixel engine: latches a batch of grey pixels and writes each
// one as a {g,g,g} word to consecutive addresses with a fixed setup/hold strobe.
module sram_pixel_writer #(
  parameter int ADDR_BITS   = 16,
  parameter int DATA_BITS   = 24,
  parameter int PIX_BITS    = 8,
  parameter int BATCH       = 20,
  parameter int WAIT_CYCLES = 3
) (
  input  logic                               clk,
  input  logic                               n_rst,
  input  logic                               start,
  input  logic [ADDR_BITS-1:0]               base_addr,
  input  logic [4:0]                         num_pix,
  input  logic [BATCH-1:0][PIX_BITS-1:0]     pix_in,
  output logic                               busy,
  output logic                               done,
  output logic [ADDR_BITS-1:0]               address,
  output logic [DATA_BITS-1:0]               w_data,
  output logic                               write_enable,
  output logic                               read_enable
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                           r_state, w_state_n;
  logic [BATCH-1:0][PIX_BITS-1:0]   r_pix, w_pix_n;
  logic [ADDR_BITS-1:0]             r_base, w_base_n;
  logic [4:0]                       r_count, w_count_n;
  logic [4:0]                       r_idx, w_idx_n;
  logic [3:0]                       r_wait, w_wait_n;
  logic                             r_busy, w_busy_n;
  logic                             r_done, w_done_n;
  logic                             r_we, w_we_n;
  logic [ADDR_BITS-1:0]             r_addr, w_addr_n;
  logic [DATA_BITS-1:0]             r_data, w_data_n;
  logic [4:0]                       w_clamp;
  logic [4:0]                       w_idx_inc;

  function automatic logic [DATA_BITS-1:0] grey(input logic [PIX_BITS-1:0] g);
    return DATA_BITS'({3{g}});
  endfunction

  assign w_clamp   = (num_pix > 5'(BATCH)) ? 5'(BATCH) : num_pix;
  assign w_idx_inc = r_idx + 5'd1;

  // Address/data are loaded on the edge that enters SETUP, so they stay
  // stable through the whole strobe window and hold in IDLE/DONE.
  always_comb begin
    w_state_n = r_state;
    w_pix_n   = r_pix;
    w_base_n  = r_base;
    w_count_n = r_count;
    w_idx_n   = r_idx;
    w_wait_n  = r_wait;
    w_addr_n  = r_addr;
    w_data_n  = r_data;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_pix_n   = pix_in;
          w_base_n  = base_addr;
          w_count_n = w_clamp;
          w_idx_n   = '0;
          w_wait_n  = '0;
          if (w_clamp != 5'd0) begin
            w_state_n = S_SETUP;
            w_addr_n  = base_addr;
            w_data_n  = grey(pix_in[0]);
          end else begin
            w_state_n = S_DONE;
          end
        end
      end
      S_SETUP: begin
        w_state_n = S_WRITE;
        w_wait_n  = '0;
      end
      S_WRITE: begin
        if (r_wait == 4'(WAIT_CYCLES - 1)) begin
          w_wait_n = '0;
          w_idx_n  = w_idx_inc;
          if (w_idx_inc == r_count) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_SETUP;
            w_addr_n  = r_base + ADDR_BITS'(w_idx_inc);
            w_data_n  = grey(r_pix[w_idx_inc]);
          end
        end else begin
          w_wait_n = r_wait + 4'd1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
    w_busy_n = (w_state_n == S_SETUP) || (w_state_n == S_WRITE);
    w_we_n   = (w_state_n == S_WRITE);
    w_done_n = (w_state_n == S_DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
      r_pix   <= '0;
      r_base  <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_wait  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_n;
      r_pix   <= w_pix_n;
      r_base  <= w_base_n;
      r_count <= w_count_n;
      r_idx   <= w_idx_n;
      r_wait  <= w_wait_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
      r_we    <= w_we_n;
      r_addr  <= w_addr_n;
      r_data  <= w_data_n;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign write_enable = r_we;
  assign address      = r_addr;
  assign w_data       = r_data;
  assign read_enable  = 1'b0;

endmodule
